csa_seq_ctrl: RTL

- Multi-cycle sequencer that performs a WORDS×4-bit addition using one shared 4-bit carry select adder (`csa`), one nibble per clock, LSB nibble first.
- Carry is held in a register between nibbles.
- Start/ready/done handshake for the surrounding datapath; the result is held stable until the next accepted operation.

---
 rtl/csa_seq_ctrl_pkg.sv | 12 +
 rtl/csa_seq_ctrl_csa.sv | 36 +++
 rtl/csa_seq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/csa_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry select adder sequencer.
package csa_seq_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csa_seq_ctrl_csa.sv
// 4-bit carry select adder: the low half ripples, and the high half is precomputed
// for both possible carries and then selected by the low-half carry.
module csa
    import csa_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             Cin,
    output logic [NIB_W-1:0] SUM,
    output logic             CARRY
);

    localparam int HALF = NIB_W / 2;

    logic [HALF:0] lo;
    logic [HALF:0] hi0;
    logic [HALF:0] hi1;

    always_comb begin
        lo  = {1'b0, A[HALF-1:0]} + {1'b0, B[HALF-1:0]} + {{HALF{1'b0}}, Cin};
        hi0 = {1'b0, A[NIB_W-1:HALF]} + {1'b0, B[NIB_W-1:HALF]};
        hi1 = {1'b0, A[NIB_W-1:HALF]} + {1'b0, B[NIB_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
    end

    always_comb begin
        SUM[HALF-1:0] = lo[HALF-1:0];
        if (lo[HALF]) begin
            SUM[NIB_W-1:HALF] = hi1[HALF-1:0];
            CARRY             = hi1[HALF];
        end else begin
            SUM[NIB_W-1:HALF] = hi0[HALF-1:0];
            CARRY             = hi0[HALF];
        end
    end

endmodule

// File: rtl/csa_seq_ctrl.sv
// Multi-cycle W-bit adder built from one shared 4-bit csa, one nibble per clock,
// LSB first. The result registers update only on entry to DONE.
module csa_seq_ctrl
    import csa_seq_ctrl_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = NIB_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] SUM,
    output logic         CARRY,
    output logic         OVF
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t state, state_nxt;

    logic [IDX_W-1:0]                  idx;
    logic                              carry_reg;
    logic [WORDS-1:0][NIB_W-1:0]       a_reg;
    logic [WORDS-1:0][NIB_W-1:0]       b_reg;
    logic [WORDS-1:0][NIB_W-1:0]       acc;
    logic [WORDS-1:0][NIB_W-1:0]       acc_nxt;

    logic [NIB_W-1:0]                  a_nib;
    logic [NIB_W-1:0]                  b_nib;
    logic [NIB_W-1:0]                  nib_sum;
    logic                              nib_carry;
    logic                              last;

    assign last = (idx == IDX_W'(WORDS - 1));

    // Nibble select and accumulator merge; the final nibble is merged here so
    // SUM can be loaded on the same edge that leaves RUN.
    always_comb begin
        a_nib   = '0;
        b_nib   = '0;
        acc_nxt = acc;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                a_nib      = a_reg[w];
                b_nib      = b_reg[w];
                acc_nxt[w] = nib_sum;
            end
        end
    end

    csa u_csa (
        .A     (a_nib),
        .B     (b_nib),
        .Cin   (carry_reg),
        .SUM   (nib_sum),
        .CARRY (nib_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        busy  = (state == RUN);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            SUM       <= '0;
            CARRY     <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        carry_reg <= Cin;
                        idx       <= '0;
                        acc       <= '0;
                    end
                end
                RUN: begin
                    acc       <= acc_nxt;
                    carry_reg <= nib_carry;
                    if (last) begin
                        SUM   <= acc_nxt;
                        CARRY <= nib_carry;
                        OVF   <= (a_reg[WORDS-1][NIB_W-1] == b_reg[WORDS-1][NIB_W-1]) &&
                                 (acc_nxt[WORDS-1][NIB_W-1] != a_reg[WORDS-1][NIB_W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
